// File: rtl/dcache_sa_wb_if.sv
// CPU MEM-stage request/response signals and the word-serial memory burst port of dcache_sa_wb.
// The master modport is the cache's view; slave is the CPU-plus-memory side.
interface dcache_sa_wb_if;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  LS_op;
  logic [31:0] Data_Out;
  logic        DStall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  Addr, WriteData, MemRead, MemWrite, LS_op, mem_rdata, mem_ready,
    output Data_Out, DStall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output Addr, WriteData, MemRead, MemWrite, LS_op, mem_rdata, mem_ready,
    input  Data_Out, DStall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_sa_wb.sv
// 2-way set-associative write-back, write-allocate data cache with same-cycle hits and
// word-serial eviction/fill bursts; the access replays from IDLE once the line is resident.
module dcache_sa_wb #(
  parameter int SETS  = 16,
  parameter int WORDS = 4
) (
  input logic            clk,
  input logic            rst,
  dcache_sa_wb_if.master bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = $clog2(WORDS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int LIN_W = IDX_W + OFF_W;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t           state;
  logic             vway;
  logic [OFF_W-1:0] cnt;
  logic [OFF_W-1:0] cnt_next;
  logic             last;

  logic [31:0]      data_mem [0:1][0:SETS*WORDS-1];
  logic [TAG_W-1:0] tag_mem  [0:1][0:SETS-1];
  logic [SETS-1:0]  valid    [0:1];
  logic [SETS-1:0]  dirty    [0:1];
  logic [SETS-1:0]  lru;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_set;
  logic [OFF_W-1:0] req_word;
  logic [1:0]       req_byte;
  logic [LIN_W-1:0] req_line_word;

  logic        access, is_load, is_store;
  logic        hit0, hit1, hit, hit_way, miss;
  logic        victim_way, victim_dirty;
  logic [31:0] hit_word, load_val, store_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] fill_base, wb_base;

  assign req_tag       = bus.Addr[31 -: TAG_W];
  assign req_set       = bus.Addr[2+OFF_W +: IDX_W];
  assign req_word      = bus.Addr[2 +: OFF_W];
  assign req_byte      = bus.Addr[1:0];
  assign req_line_word = {req_set, req_word};

  assign access   = bus.MemRead | bus.MemWrite;
  assign is_load  = bus.MemRead;
  assign is_store = bus.MemWrite & ~bus.MemRead;

  assign hit0    = valid[0][req_set] && (tag_mem[0][req_set] == req_tag);
  assign hit1    = valid[1][req_set] && (tag_mem[1][req_set] == req_tag);
  assign hit     = hit0 | hit1;
  assign hit_way = hit1;
  assign miss    = (state == IDLE) & access & ~hit;

  // An empty way is always filled before anything resident is displaced.
  assign victim_way   = !valid[0][req_set] ? 1'b0 : (!valid[1][req_set] ? 1'b1 : lru[req_set]);
  assign victim_dirty = valid[victim_way][req_set] & dirty[victim_way][req_set];

  assign fill_base = {req_tag, req_set, {OFF_W{1'b0}}, 2'b00};
  assign wb_base   = {tag_mem[victim_way][req_set], req_set, {OFF_W{1'b0}}, 2'b00};

  assign cnt_next = cnt + OFF_W'(1);
  assign last     = (cnt == OFF_W'(WORDS - 1));

  assign hit_word = data_mem[hit_way][req_line_word];
  assign ld_byte  = hit_word[{req_byte, 3'b000} +: 8];
  assign ld_half  = hit_word[{req_byte[1], 4'b0000} +: 16];

  always_comb begin
    load_val = hit_word;
    case (bus.LS_op)
      LS_B:    load_val = {{24{ld_byte[7]}}, ld_byte};
      LS_BU:   load_val = {24'd0, ld_byte};
      LS_H:    load_val = {{16{ld_half[15]}}, ld_half};
      LS_HU:   load_val = {16'd0, ld_half};
      LS_W:    load_val = hit_word;
      default: load_val = hit_word;
    endcase
  end

  always_comb begin
    store_word = hit_word;
    case (bus.LS_op)
      LS_B:    store_word[{req_byte, 3'b000} +: 8] = bus.WriteData[7:0];
      LS_H:    store_word[{req_byte[1], 4'b0000} +: 16] = bus.WriteData[15:0];
      default: store_word = bus.WriteData;
    endcase
  end

  assign bus.Data_Out = ((state == IDLE) && is_load && hit) ? load_val : 32'd0;
  assign bus.DStall   = ~rst & ((state != IDLE) | miss);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      vway          <= 1'b0;
      cnt           <= '0;
      valid[0]      <= '0;
      valid[1]      <= '0;
      dirty[0]      <= '0;
      dirty[1]      <= '0;
      lru           <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (access && hit) begin
            lru[req_set] <= ~hit_way;
            if (is_store) dirty[hit_way][req_set] <= 1'b1;
          end else if (access) begin
            vway        <= victim_way;
            cnt         <= '0;
            bus.mem_req <= 1'b1;
            if (victim_dirty) begin
              state         <= WB;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= wb_base;
              bus.mem_wdata <= data_mem[victim_way][{req_set, {OFF_W{1'b0}}}];
            end else begin
              state        <= FILL;
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= fill_base;
            end
          end
        end
        WB: begin
          if (bus.mem_ready) begin
            if (last) begin
              state         <= FILL;
              cnt           <= '0;
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= fill_base;
              bus.mem_wdata <= 32'd0;
            end else begin
              cnt           <= cnt_next;
              bus.mem_addr  <= bus.mem_addr + 32'd4;
              bus.mem_wdata <= data_mem[vway][{req_set, cnt_next}];
            end
          end
        end
        FILL: begin
          if (bus.mem_ready) begin
            if (last) begin
              state              <= IDLE;
              cnt                <= '0;
              valid[vway][req_set] <= 1'b1;
              dirty[vway][req_set] <= 1'b0;
              lru[req_set]       <= ~vway;
              bus.mem_req        <= 1'b0;
              bus.mem_addr       <= 32'd0;
            end else begin
              cnt          <= cnt_next;
              bus.mem_addr <= bus.mem_addr + 32'd4;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; valid bits alone decide what is resident.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && is_store && hit)
      data_mem[hit_way][req_line_word] <= store_word;
    if ((state == FILL) && bus.mem_ready) begin
      data_mem[vway][{req_set, cnt}] <= bus.mem_rdata;
      if (last) tag_mem[vway][req_set] <= req_tag;
    end
  end
endmodule

// File: tb/tb_dcache_sa_wb.sv
// Scoreboard bench for dcache_sa_wb: a line-level reference model predicts load data, burst
// traffic and stall length; a negedge monitor compares whatever the DUT presents.
module tb_dcache_sa_wb;
  localparam int SETS  = 16;
  localparam int WORDS = 4;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_sa_wb_if bus ();

  dcache_sa_wb #(.SETS(SETS), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_load;
    logic [31:0] data;
    logic [7:0]  xfers;
    logic        has_stall;
    logic [7:0]  stall;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  exp_t  exp_q [$];
  xfer_t xfer_q [$];

  // Reference model: backing memory, CPU-visible contents of resident lines, and per-set MRU/LRU line.
  logic [31:0] bmem [int unsigned];
  logic [31:0] cdata [int unsigned];
  logic        dirty_line [int unsigned];
  logic [31:0] mru_line [SETS];
  logic [31:0] lru_line [SETS];
  int          line_cnt [SETS];

  int mode = 0;
  int rcnt = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%08h required=%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] bread(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return (a * 32'h0100_0193) ^ 32'h9E37_79B9;
  endfunction

  function automatic void model_reset();
    cdata.delete();
    dirty_line.delete();
    for (int s = 0; s < SETS; s++) line_cnt[s] = 0;
  endfunction

  function automatic void model_access(input logic [31:0] a, input logic rd, input logic wr,
                                       input logic [2:0] op, input logic [31:0] wd,
                                       output logic [31:0] ld, output int xf);
    logic [31:0] la, wa, victim, w, b, h, nw;
    int s, sh;
    la = a & ~32'hF;
    wa = a & ~32'h3;
    s  = int'((a >> 4) % SETS);
    xf = 0;
    ld = 32'd0;
    if (line_cnt[s] >= 1 && mru_line[s] == la) begin
      xf = 0;
    end else if (line_cnt[s] == 2 && lru_line[s] == la) begin
      lru_line[s] = mru_line[s];
      mru_line[s] = la;
    end else begin
      if (line_cnt[s] == 2) begin
        victim = lru_line[s];
        if (dirty_line.exists(victim)) begin
          for (int i = 0; i < WORDS; i++) begin
            xfer_q.push_back({1'b1, victim + 32'(4 * i), cdata[victim + 32'(4 * i)]});
            bmem[victim + 32'(4 * i)] = cdata[victim + 32'(4 * i)];
            xf++;
          end
          dirty_line.delete(victim);
        end
        for (int i = 0; i < WORDS; i++) cdata.delete(victim + 32'(4 * i));
        lru_line[s] = mru_line[s];
      end else if (line_cnt[s] == 1) begin
        lru_line[s] = mru_line[s];
        line_cnt[s] = 2;
      end else begin
        line_cnt[s] = 1;
      end
      mru_line[s] = la;
      for (int i = 0; i < WORDS; i++) begin
        xfer_q.push_back({1'b0, la + 32'(4 * i), 32'd0});
        cdata[la + 32'(4 * i)] = bread(la + 32'(4 * i));
        xf++;
      end
    end
    w  = cdata[wa];
    sh = int'(a[1:0]) * 8;
    b  = (w >> sh) & 32'hFF;
    h  = (w >> (int'(a[1]) * 16)) & 32'hFFFF;
    if (rd) begin
      case (op)
        OP_B:    ld = (b >= 128) ? b - 32'd256 : b;
        OP_H:    ld = (h >= 32768) ? h - 32'd65536 : h;
        OP_BU:   ld = b;
        OP_HU:   ld = h;
        default: ld = w;
      endcase
    end else if (wr) begin
      case (op)
        OP_B:    nw = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        OP_H:    nw = (w & ~(32'hFFFF << (int'(a[1]) * 16))) | ((wd & 32'hFFFF) << (int'(a[1]) * 16));
        default: nw = wd;
      endcase
      cdata[wa] = nw;
      dirty_line[la] = 1'b1;
    end
  endfunction

  task automatic finish_now(input string why);
    errors++;
    $display("[TB] FAIL %s actual=timeout required=progress", why);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] aborted");
  endtask

  // Issues one access, queues its expectations, and holds it until the cache stops stalling.
  task automatic apply_stimulus(input logic [31:0] a, input logic rd, input logic wr,
                                input logic [2:0] op, input logic [31:0] wd,
                                input logic use_data, input logic [31:0] data_const,
                                input int stall_const, input int gap);
    exp_t e;
    logic [31:0] ld;
    int xf, n;
    model_access(a, rd, wr, op, wd, ld, xf);
    e.is_load   = rd;
    e.data      = use_data ? data_const : ld;
    e.xfers     = 8'(xf);
    e.has_stall = (stall_const >= 0);
    e.stall     = 8'(stall_const);
    exp_q.push_back(e);
    bus.Addr      = a;
    bus.WriteData = wd;
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.LS_op     = op;
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.DStall) break;
      n++;
      if (n > 1000) finish_now("stall_timeout");
    end
    @(posedge clk);
    #1;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory responder: mode 0 always ready, 1 random, 2 three wait cycles before every word.
  always @(posedge clk) begin
    #1;
    case (mode)
      0: bus.mem_ready = 1'b1;
      1: bus.mem_ready = 1'($urandom_range(0, 1));
      default: begin
        if (!bus.mem_req) begin
          rcnt = 0;
          bus.mem_ready = 1'b0;
        end else begin
          bus.mem_ready = (rcnt == 3);
          rcnt = bus.mem_ready ? 0 : rcnt + 1;
        end
      end
    endcase
    bus.mem_rdata = bread(bus.mem_addr);
  end

  int          stall_cnt = 0;
  int          wait_cnt = 0;
  int          xfer_count = 0;
  logic        held_valid = 1'b0;
  logic        held_we;
  logic [31:0] held_addr, held_wdata;
  exp_t        mon_e;
  xfer_t       mon_x;
  int          mon_stall;

  always @(negedge clk) begin
    if (rst) begin
      stall_cnt  = 0;
      wait_cnt   = 0;
      held_valid = 1'b0;
    end else begin
      if (bus.mem_req && held_valid) begin
        check_output("hold_addr", bus.mem_addr, held_addr);
        check_output("hold_we", 32'(bus.mem_we), 32'(held_we));
        check_output("hold_wdata", bus.mem_wdata, held_wdata);
      end
      held_valid = bus.mem_req && !bus.mem_ready;
      held_addr  = bus.mem_addr;
      held_we    = bus.mem_we;
      held_wdata = bus.mem_wdata;
      if (bus.mem_req && bus.mem_ready) begin
        xfer_count++;
        if (xfer_q.size() == 0) begin
          check_output("xfer_unexpected", bus.mem_addr, 32'hFFFF_FFFF);
        end else begin
          mon_x = xfer_q.pop_front();
          check_output("xfer_addr", bus.mem_addr, mon_x.addr);
          check_output("xfer_we", 32'(bus.mem_we), 32'(mon_x.we));
          if (mon_x.we) check_output("xfer_wdata", bus.mem_wdata, mon_x.wdata);
        end
      end
      if (bus.mem_req && !bus.mem_ready) wait_cnt++;
      if ((bus.MemRead || bus.MemWrite) && bus.DStall) begin
        stall_cnt++;
        check_output("stall_dout", bus.Data_Out, 32'd0);
      end else if (bus.MemRead || bus.MemWrite) begin
        if (exp_q.size() == 0) begin
          check_output("resp_unexpected", bus.Data_Out, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.is_load) check_output("load_data", bus.Data_Out, mon_e.data);
          else check_output("store_dout", bus.Data_Out, 32'd0);
          if (mon_e.has_stall) mon_stall = int'(mon_e.stall);
          else mon_stall = (mon_e.xfers == 0) ? 0 : 1 + int'(mon_e.xfers) + wait_cnt;
          check_output("stall_cycles", 32'(stall_cnt), 32'(mon_stall));
          check_output("done_mem_req", 32'(bus.mem_req), 32'd0);
        end
        stall_cnt = 0;
        wait_cnt  = 0;
      end else begin
        check_output("idle_dout", bus.Data_Out, 32'd0);
        check_output("idle_stall", 32'(bus.DStall), 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] a, wd;
    logic [2:0]  op;
    int          r, base, n;
    logic [2:0]  load_ops [5];
    logic [2:0]  store_ops [3];
    load_ops  = '{OP_B, OP_H, OP_W, OP_BU, OP_HU};
    store_ops = '{OP_B, OP_H, OP_W};

    bus.Addr = 32'd0; bus.WriteData = 32'd0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    bus.LS_op = 3'd0; bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
    bmem[32'h100] = 32'h80FF7F01;
    bmem[32'h104] = 32'h22222222;
    bmem[32'h108] = 32'h33333333;
    bmem[32'h10C] = 32'h44444444;
    model_reset();

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_dout", bus.Data_Out, 32'd0);
    check_output("rst_dstall", 32'(bus.DStall), 32'd0);
    check_output("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_output("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_output("rst_mem_addr", bus.mem_addr, 32'd0);
    check_output("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    apply_stimulus(32'h104, 1, 0, OP_W, 0, 1, 32'h22222222, 5, 1);
    apply_stimulus(32'h101, 1, 0, OP_B, 0, 1, 32'h0000007F, 0, 0);
    apply_stimulus(32'h103, 1, 0, OP_B, 0, 1, 32'hFFFFFF80, 0, 0);
    apply_stimulus(32'h103, 1, 0, OP_BU, 0, 1, 32'h00000080, 0, 0);
    apply_stimulus(32'h102, 1, 0, OP_H, 0, 1, 32'hFFFF80FF, 0, 0);
    apply_stimulus(32'h100, 1, 0, OP_HU, 0, 1, 32'h00007F01, 0, 1);
    apply_stimulus(32'h102, 0, 1, OP_B, 32'h000000AB, 0, 0, 0, 0);
    apply_stimulus(32'h100, 1, 0, OP_W, 0, 1, 32'h80AB7F01, 0, 1);
    apply_stimulus(32'h200, 1, 0, OP_W, 0, 0, 0, 5, 0);
    apply_stimulus(32'h200, 1, 0, OP_W, 0, 0, 0, 0, 0);
    apply_stimulus(32'h300, 1, 0, OP_W, 0, 0, 0, 9, 1);

    mode = 2;
    apply_stimulus(32'h504, 1, 0, OP_W, 0, 0, 0, 17, 1);
    mode = 0;

    // Abort a fill after its second word; the reset must discard everything resident.
    begin
      exp_t e;
      logic [31:0] ld;
      int xf;
      model_access(32'h400, 1, 0, OP_W, 0, ld, xf);
      e = '{is_load: 1'b1, data: ld, xfers: 8'(xf), has_stall: 1'b0, stall: 8'd0};
      exp_q.push_back(e);
      base = xfer_count;
      bus.Addr = 32'h400; bus.LS_op = OP_W; bus.MemRead = 1'b1;
      n = 0;
      while (xfer_count - base < 2) begin
        @(posedge clk);
        n++;
        if (n > 100) finish_now("burst_timeout");
      end
      #1;
      rst = 1'b1;
      bus.MemRead = 1'b0;
      #1;
      check_output("abort_mem_req", 32'(bus.mem_req), 32'd0);
      check_output("abort_dstall", 32'(bus.DStall), 32'd0);
      exp_q.delete();
      xfer_q.delete();
      model_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
    end
    apply_stimulus(32'h100, 1, 0, OP_W, 0, 1, 32'h80AB7F01, 5, 1);

    mode = 1;
    for (int i = 0; i < 400; i++) begin
      a  = ({29'd0, 3'($urandom_range(0, 7))} << 8) | ({30'd0, 2'($urandom_range(0, 3))} << 4)
           | 32'($urandom_range(0, 15));
      wd = $urandom;
      r  = $urandom_range(0, 9);
      if (r < 4) begin
        op = load_ops[$urandom_range(0, 4)];
        apply_stimulus(a, 1, 0, op, wd, 0, 0, -1, $urandom_range(0, 1));
      end else if (r < 9) begin
        op = store_ops[$urandom_range(0, 2)];
        apply_stimulus(a, 0, 1, op, wd, 0, 0, -1, $urandom_range(0, 1));
      end else begin
        op = load_ops[$urandom_range(0, 4)];
        apply_stimulus(a, 1, 1, op, wd, 0, 0, -1, $urandom_range(0, 1));
      end
    end

    repeat (3) @(negedge clk);
    check_output("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check_output("xfer_q_drained", 32'(xfer_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
